// File: rtl/alb_pkg.sv
// Shared types and constants for the ALB stimulus generator.
package alb_pkg;

  // Generator sequencing states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CORNER = 2'd1,
    RANDOM = 2'd2,
    DONE   = 2'd3
  } alb_gen_state_t;

  // Galois feedback mask for x^32 + x^22 + x^2 + x + 1.
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

  // Corner-case vectors issued ahead of the random ones for every opcode.
  localparam int          CORNER_COUNT = 4;
  localparam logic [1:0]  CORNER_ZERO  = 2'd0;  // a=0,    b=0,    ci=0
  localparam logic [1:0]  CORNER_ONES  = 2'd1;  // a=ONES, b=1,    ci=0
  localparam logic [1:0]  CORNER_MAXS  = 2'd2;  // a=MAXS, b=1,    ci=0
  localparam logic [1:0]  CORNER_MINS  = 2'd3;  // a=MINS, b=ONES, ci=1

  // One step of the right-shifting Galois LFSR.
  function automatic logic [31:0] lfsr_step(input logic [31:0] cur);
    return (cur >> 1) ^ (cur[0] ? LFSR_MASK : 32'h0000_0000);
  endfunction

  // An all-zero state would lock the LFSR, so zero seeds become 1.
  function automatic logic [31:0] seed_fix(input logic [31:0] s);
    return (s == 32'h0000_0000) ? 32'h0000_0001 : s;
  endfunction

endpackage

// File: rtl/alb_lfsr32.sv
// 32-bit Galois LFSR with synchronous seed load and step enable.
module alb_lfsr32
  import alb_pkg::*;
#(
  parameter logic [31:0] RESET_VALUE = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        enable,
  output logic [31:0] value
);

  logic [31:0] value_q;
  logic [31:0] value_d;

  // Load takes priority over stepping.
  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = seed_fix(seed);
    end else if (enable) begin
      value_d = lfsr_step(value_q);
    end
  end

  // LFSR state register; reset loads the seed so a run never starts from zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value_q <= seed_fix(RESET_VALUE);
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/alb_stimulus_gen.sv
// Operand/opcode stream generator: per opcode, four corner cases then
// NUM_RANDOM LFSR-derived vectors, with hold-based stalling and completion flag.
module alb_stimulus_gen
  import alb_pkg::*;
#(
  parameter int          DATA_WIDTH = 8,
  parameter int          OP_WIDTH   = 3,
  parameter int          NUM_RANDOM = 64,
  parameter logic [31:0] SEED       = 32'hACE1_0001
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  hold,
  output logic [DATA_WIDTH-1:0] a,
  output logic [DATA_WIDTH-1:0] b,
  output logic [OP_WIDTH-1:0]   op,
  output logic                  ci,
  output logic                  valid,
  output logic                  done,
  output logic [15:0]           vec_count
);

  localparam logic [DATA_WIDTH-1:0] ONES = {DATA_WIDTH{1'b1}};
  localparam logic [DATA_WIDTH-1:0] MAXS = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] MINS = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] ONE  = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [15:0]           LAST_CORNER = 16'(CORNER_COUNT - 1);
  localparam logic [15:0]           LAST_RANDOM = 16'(NUM_RANDOM - 1);
  localparam logic [OP_WIDTH-1:0]   LAST_OP     = {OP_WIDTH{1'b1}};

  alb_gen_state_t        state_q, state_d;
  logic [15:0]           idx_q, idx_d;
  logic [OP_WIDTH-1:0]   op_q, op_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic                  ci_q, ci_d;
  logic                  valid_q, valid_d;
  logic                  done_q, done_d;
  logic [15:0]           cnt_q, cnt_d;

  logic                  accept;
  logic                  lfsr_load;
  logic                  lfsr_en;
  logic [31:0]           lfsr_value;
  logic [31:0]           rand_src;
  logic                  rand_unused;
  logic [1:0]            corner_sel;
  logic [DATA_WIDTH-1:0] corner_a;
  logic [DATA_WIDTH-1:0] corner_b;
  logic                  corner_ci;

  alb_lfsr32 #(
    .RESET_VALUE(SEED)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (lfsr_load),
    .seed  (SEED),
    .enable(lfsr_en),
    .value (lfsr_value)
  );

  // A shown vector is consumed only when it is valid and not stalled.
  assign accept = valid_q && !hold;

  // Entering RANDOM shows the LFSR as-is; inside RANDOM the next vector is one step ahead.
  assign rand_src    = (state_q == RANDOM) ? lfsr_step(lfsr_value) : lfsr_value;
  assign rand_unused = ^rand_src[30:2*DATA_WIDTH];

  // The corner to present next: successor index inside CORNER, otherwise the first one.
  assign corner_sel = (state_q == CORNER) ? (idx_q[1:0] + 2'd1) : CORNER_ZERO;

  // Corner-case operand mux.
  always_comb begin
    corner_a  = '0;
    corner_b  = '0;
    corner_ci = 1'b0;
    case (corner_sel)
      CORNER_ONES: begin
        corner_a = ONES;
        corner_b = ONE;
      end
      CORNER_MAXS: begin
        corner_a = MAXS;
        corner_b = ONE;
      end
      CORNER_MINS: begin
        corner_a  = MINS;
        corner_b  = ONES;
        corner_ci = 1'b1;
      end
      default: begin
        corner_a  = '0;
        corner_b  = '0;
        corner_ci = 1'b0;
      end
    endcase
  end

  // Next-state logic: sequencing, counters and the vector to present next cycle.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    ci_d      = ci_q;
    valid_d   = valid_q;
    done_d    = done_q;
    cnt_d     = cnt_q;
    lfsr_load = 1'b0;
    lfsr_en   = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        // Restart is not gated by hold; hold only blocks acceptance.
        if (start) begin
          state_d   = CORNER;
          idx_d     = '0;
          op_d      = '0;
          cnt_d     = '0;
          lfsr_load = 1'b1;
          a_d       = corner_a;
          b_d       = corner_b;
          ci_d      = corner_ci;
          valid_d   = 1'b1;
          done_d    = 1'b0;
        end
      end

      CORNER: begin
        if (accept) begin
          cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
          if (idx_q == LAST_CORNER) begin
            state_d = RANDOM;
            idx_d   = '0;
            a_d     = rand_src[DATA_WIDTH-1:0];
            b_d     = rand_src[2*DATA_WIDTH-1:DATA_WIDTH];
            ci_d    = rand_src[31];
          end else begin
            idx_d = idx_q + 16'd1;
            a_d   = corner_a;
            b_d   = corner_b;
            ci_d  = corner_ci;
          end
        end
      end

      RANDOM: begin
        if (accept) begin
          cnt_d   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
          lfsr_en = 1'b1;
          if (idx_q == LAST_RANDOM) begin
            if (op_q == LAST_OP) begin
              // Outputs keep the last vector; only the flags change.
              state_d = DONE;
              valid_d = 1'b0;
              done_d  = 1'b1;
            end else begin
              state_d = CORNER;
              idx_d   = '0;
              op_d    = op_q + 1'b1;
              a_d     = corner_a;
              b_d     = corner_b;
              ci_d    = corner_ci;
            end
          end else begin
            idx_d = idx_q + 16'd1;
            a_d   = rand_src[DATA_WIDTH-1:0];
            b_d   = rand_src[2*DATA_WIDTH-1:DATA_WIDTH];
            ci_d  = rand_src[31];
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM and registered outputs; reset clears everything immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      ci_q    <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ci_q    <= ci_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign op        = op_q;
  assign ci        = ci_q;
  assign valid     = valid_q;
  assign done      = done_q;
  assign vec_count = cnt_q;

endmodule
